// File: rtl/motion_pkg.sv
// Shared types and the saturating subtract used by the motion setpoint table.
// Optional feature macro: MOTION_VEL_CLAMP_EN (consumed by motion_axis_calc).
package motion_pkg;

  // Read-port field selector encoding.
  typedef enum logic [1:0] {
    RSEL_POS = 2'b00,
    RSEL_TGT = 2'b01,
    RSEL_VEL = 2'b10,
    RSEL_ACC = 2'b11
  } rsel_t;

  // Update engine states.
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    CALC   = 2'b01,
    COMMIT = 2'b10
  } state_t;

  // a - b saturated to a w-bit signed range. Operands arrive sign-extended
  // to 64 bits, so the raw difference of two w-bit values never wraps here
  // (valid for w <= 63).
  function automatic logic signed [63:0] sat_sub(input logic signed [63:0] a,
                                                 input logic signed [63:0] b,
                                                 input int w);
    logic signed [63:0] diff;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    diff = a - b;
    hi   = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo   = -(64'sd1 <<< (w - 1));
    if (diff > hi)      return hi;
    else if (diff < lo) return lo;
    else                return diff;
  endfunction

endpackage

// File: rtl/motion_axis_calc.sv
// Combinational per-axis velocity / acceleration / next-position calculator.
// Time-shared across all axes by the table's update engine.
// Optional feature macro: MOTION_VEL_CLAMP_EN limits |v| to VEL_LIMIT and
// lets the committed position trail the target by the clamped step.
module motion_axis_calc
  import motion_pkg::*;
#(
  parameter int     W         = 32,
  parameter longint VEL_LIMIT = 64'sd1 <<< (W - 2)
) (
  input  logic signed [W-1:0] tgt,
  input  logic signed [W-1:0] cur,
  input  logic signed [W-1:0] vel,
  output logic signed [W-1:0] v,
  output logic signed [W-1:0] a,
  output logic signed [W-1:0] pos
);

`ifdef MOTION_VEL_CLAMP_EN
  localparam bit CLAMP_EN = 1'b1;
`else
  localparam bit CLAMP_EN = 1'b0;
`endif

  localparam logic signed [W-1:0] LIM = W'(VEL_LIMIT);

  logic signed [W-1:0] v_sat;
  logic signed [W-1:0] v_lim;

  // Saturated velocity, optional magnitude clamp, then acceleration from it.
  always_comb begin
    v_sat = W'(sat_sub(64'(tgt), 64'(cur), W));
    v_lim = v_sat;
    if (CLAMP_EN) begin
      if (v_sat > LIM)       v_lim = LIM;
      else if (v_sat < -LIM) v_lim = -LIM;
    end
    v   = v_lim;
    a   = W'(sat_sub(64'(v_lim), 64'(vel), W));
    // Without the clamp the axis lands exactly on its target.
    pos = CLAMP_EN ? W'(sat_sub(64'(cur), -64'(v_lim), W)) : tgt;
  end

endmodule

// File: rtl/motion_setpoint_table.sv
// N-axis setpoint/velocity table: double-buffered host targets, a serial
// one-axis-per-cycle update engine and an atomic commit of all axes.
// Optional feature macro: MOTION_VEL_CLAMP_EN (velocity clamp, see
// motion_axis_calc).
module motion_setpoint_table
  import motion_pkg::*;
#(
  parameter int     N_AXES    = 3,
  parameter int     W         = 32,
  parameter longint VEL_LIMIT = 64'sd1 <<< (W - 2),
  localparam int    AW        = (N_AXES > 1) ? $clog2(N_AXES) : 1
) (
  input  logic          clk,
  input  logic          N_reset,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [W-1:0]  wd,
  input  logic          update,
  input  logic          clr_overrun,
  input  logic [AW-1:0] ra,
  input  logic [1:0]    rsel,
  output logic [W-1:0]  rd,
  output logic          busy,
  output logic          done,
  output logic          overrun
);

  logic signed [W-1:0] shadow     [N_AXES];
  logic signed [W-1:0] active_tgt [N_AXES];
  logic signed [W-1:0] cur        [N_AXES];
  logic signed [W-1:0] vel        [N_AXES];
  logic signed [W-1:0] acc        [N_AXES];
  logic signed [W-1:0] stg_vel    [N_AXES];
  logic signed [W-1:0] stg_acc    [N_AXES];
  logic signed [W-1:0] stg_pos    [N_AXES];

  state_t        state;
  logic [AW-1:0] idx;

  logic signed [W-1:0] calc_v;
  logic signed [W-1:0] calc_a;
  logic signed [W-1:0] calc_pos;

  motion_axis_calc #(
    .W         (W),
    .VEL_LIMIT (VEL_LIMIT)
  ) u_calc (
    .tgt (active_tgt[idx]),
    .cur (cur[idx]),
    .vel (vel[idx]),
    .v   (calc_v),
    .a   (calc_a),
    .pos (calc_pos)
  );

  assign busy = (state != IDLE);

  // Host shadow writes, accepted in any state; out-of-range axes match nothing.
  always_ff @(posedge clk or negedge N_reset) begin
    if (!N_reset) begin
      for (int i = 0; i < N_AXES; i++) shadow[i] <= '0;
    end else begin
      for (int i = 0; i < N_AXES; i++)
        if (we && wa == AW'(i)) shadow[i] <= wd;
    end
  end

  // Update engine: snapshot, serial per-axis calculation, atomic commit.
  always_ff @(posedge clk or negedge N_reset) begin
    if (!N_reset) begin
      state   <= IDLE;
      idx     <= '0;
      done    <= 1'b0;
      overrun <= 1'b0;
      for (int i = 0; i < N_AXES; i++) begin
        active_tgt[i] <= '0;
        cur[i]        <= '0;
        vel[i]        <= '0;
        acc[i]        <= '0;
        stg_vel[i]    <= '0;
        stg_acc[i]    <= '0;
        stg_pos[i]    <= '0;
      end
    end else begin
      done <= 1'b0;
      // A new overrun beats a simultaneous clear.
      if (update && state != IDLE) overrun <= 1'b1;
      else if (clr_overrun)        overrun <= 1'b0;

      case (state)
        IDLE: begin
          if (update) begin
            // Non-blocking read of shadow: a same-cycle write is not captured.
            for (int i = 0; i < N_AXES; i++) active_tgt[i] <= shadow[i];
            idx   <= '0;
            state <= CALC;
          end
        end
        CALC: begin
          stg_vel[idx] <= calc_v;
          stg_acc[idx] <= calc_a;
          stg_pos[idx] <= calc_pos;
          if (idx == AW'(N_AXES - 1)) state <= COMMIT;
          else                        idx   <= idx + 1'b1;
        end
        COMMIT: begin
          for (int i = 0; i < N_AXES; i++) begin
            cur[i] <= stg_pos[i];
            vel[i] <= stg_vel[i];
            acc[i] <= stg_acc[i];
          end
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Read mux over committed values and the shadow targets.
  always_comb begin
    rd = '0;
    if (int'(ra) < N_AXES) begin
      case (rsel_t'(rsel))
        RSEL_POS: rd = cur[ra];
        RSEL_TGT: rd = shadow[ra];
        RSEL_VEL: rd = vel[ra];
        RSEL_ACC: rd = acc[ra];
        default:  rd = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_motion_setpoint_table.sv
// Directed self-checking bench for motion_setpoint_table (3 axes, 32 bits).
// Build with MOTION_VEL_CLAMP_EN defined to run the velocity-clamp sequence.
module tb_motion_setpoint_table;

`ifdef MOTION_VEL_CLAMP_EN
  localparam longint VLIM = 10;
`else
  localparam longint VLIM = 64'sd1 <<< 30;
`endif

  logic        clk = 1'b0;
  logic        N_reset;
  logic        we;
  logic [1:0]  wa;
  logic [31:0] wd;
  logic        update;
  logic        clr_overrun;
  logic [1:0]  ra;
  logic [1:0]  rsel;
  logic [31:0] rd;
  logic        busy;
  logic        done;
  logic        overrun;

  int n_checks = 0;
  int n_fail   = 0;
  int bc;
  int dp;

  motion_setpoint_table #(
    .N_AXES    (3),
    .W         (32),
    .VEL_LIMIT (VLIM)
  ) dut (
    .clk         (clk),
    .N_reset     (N_reset),
    .we          (we),
    .wa          (wa),
    .wd          (wd),
    .update      (update),
    .clr_overrun (clr_overrun),
    .ra          (ra),
    .rsel        (rsel),
    .rd          (rd),
    .busy        (busy),
    .done        (done),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d (0x%08h) expected %0d (0x%08h)",
             tag, $signed(obs), obs, $signed(exp), exp);
    end
    $display("check %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic rchk(input logic [1:0] axis, input logic [1:0] sel, input logic [31:0] exp);
    @(negedge clk);
    ra   = axis;
    rsel = sel;
    #1;
    chk($sformatf("rd ax%0d sel%0d", axis, sel), rd, exp);
  endtask

  task automatic wr(input logic [1:0] axis, input logic [31:0] data);
    @(negedge clk);
    we = 1'b1; wa = axis; wd = data;
    @(negedge clk);
    we = 1'b0;
  endtask

  // Strobe update for 'hold' cycles (optionally with a concurrent write) and
  // count busy cycles and done pulses over a fixed window.
  task automatic do_update(input int hold, input logic wen, input logic [1:0] wax,
                           input logic [31:0] wdat, output int busy_cnt, output int done_cnt);
    @(negedge clk);
    update = 1'b1; we = wen; wa = wax; wd = wdat;
    busy_cnt = 0;
    done_cnt = 0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (k == 1)    we = 1'b0;
      if (k >= hold) update = 1'b0;
      if (busy) busy_cnt++;
      if (done) done_cnt++;
    end
  endtask

  initial begin
    N_reset = 1'b0; we = 1'b0; wa = '0; wd = '0; update = 1'b0;
    clr_overrun = 1'b0; ra = '0; rsel = '0;
    repeat (3) @(negedge clk);
    N_reset = 1'b1;

    // Reset state
    for (int a = 0; a < 3; a++)
      for (int s = 0; s < 4; s++) rchk(2'(a), 2'(s), 32'd0);
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset done", {31'd0, done}, 32'd0);
    chk("reset overrun", {31'd0, overrun}, 32'd0);

`ifdef MOTION_VEL_CLAMP_EN
    // Velocity clamp: position walks toward the target in steps of 10.
    wr(2'd0, 32'd25);
    do_update(1, 1'b0, 2'd0, 32'd0, bc, dp);
    rchk(2'd0, 2'b10, 32'd10);
    rchk(2'd0, 2'b00, 32'd10);
    rchk(2'd0, 2'b11, 32'd10);
    do_update(1, 1'b0, 2'd0, 32'd0, bc, dp);
    rchk(2'd0, 2'b10, 32'd10);
    rchk(2'd0, 2'b00, 32'd20);
    rchk(2'd0, 2'b11, 32'd0);
    do_update(1, 1'b0, 2'd0, 32'd0, bc, dp);
    rchk(2'd0, 2'b10, 32'd5);
    rchk(2'd0, 2'b00, 32'd25);
    rchk(2'd0, 2'b11, -32'sd5);
`else
    begin
      logic [31:0] e1 [3];
      e1[0] = 32'd100; e1[1] = -32'sd50; e1[2] = 32'd7;

      // First update: everything follows the targets from zero.
      wr(2'd0, e1[0]); wr(2'd1, e1[1]); wr(2'd2, e1[2]);
      do_update(1, 1'b0, 2'd0, 32'd0, bc, dp);
      chk("upd1 busy cycles", 32'(bc), 32'd4);
      chk("upd1 done pulses", 32'(dp), 32'd1);
      for (int a = 0; a < 3; a++)
        for (int s = 0; s < 4; s++) rchk(2'(a), 2'(s), e1[a]);
      for (int s = 0; s < 4; s++) rchk(2'd3, 2'(s), 32'd0);

      // Write to a nonexistent axis leaves the real shadows alone.
      wr(2'd3, 32'd999);
      for (int a = 0; a < 3; a++) rchk(2'(a), 2'b01, e1[a]);

      // Second update; axis 1 written in the strobe cycle keeps its old snapshot.
      wr(2'd0, 32'd150);
      do_update(1, 1'b1, 2'd1, -32'sd1000, bc, dp);
      rchk(2'd0, 2'b00, 32'd150);
      rchk(2'd0, 2'b10, 32'd50);
      rchk(2'd0, 2'b11, -32'sd50);
      rchk(2'd1, 2'b00, -32'sd50);
      rchk(2'd1, 2'b10, 32'd0);
      rchk(2'd1, 2'b11, 32'd50);
      rchk(2'd1, 2'b01, -32'sd1000);
      rchk(2'd2, 2'b10, 32'd0);
      rchk(2'd2, 2'b11, -32'sd7);

      // Saturation toward the negative and positive rails.
      wr(2'd0, 32'h8000_0000);
      do_update(1, 1'b0, 2'd0, 32'd0, bc, dp);
      rchk(2'd0, 2'b00, 32'h8000_0000);
      rchk(2'd0, 2'b10, 32'h8000_0000);
      rchk(2'd0, 2'b11, 32'h8000_0000);
      wr(2'd0, 32'h7FFF_FFFF);
      do_update(1, 1'b0, 2'd0, 32'd0, bc, dp);
      rchk(2'd0, 2'b10, 32'h7FFF_FFFF);
      rchk(2'd0, 2'b11, 32'h7FFF_FFFF);
      rchk(2'd0, 2'b00, 32'h7FFF_FFFF);

      // Update strobed again during CALC: ignored, overrun flagged.
      wr(2'd0, 32'd10);
      do_update(2, 1'b0, 2'd0, 32'd0, bc, dp);
      chk("ovr busy cycles", 32'(bc), 32'd4);
      chk("ovr done pulses", 32'(dp), 32'd1);
      chk("ovr flag set", {31'd0, overrun}, 32'd1);
      rchk(2'd0, 2'b10, 32'h8000_000B);
      rchk(2'd0, 2'b11, 32'h8000_0000);
      rchk(2'd0, 2'b00, 32'd10);
      @(negedge clk); clr_overrun = 1'b1;
      @(negedge clk); clr_overrun = 1'b0;
      chk("ovr cleared", {31'd0, overrun}, 32'd0);

      // Overrun set and clear in the same cycle: set wins.
      @(negedge clk); update = 1'b1;
      @(negedge clk); clr_overrun = 1'b1;
      @(negedge clk); update = 1'b0; clr_overrun = 1'b0;
      chk("ovr set wins", {31'd0, overrun}, 32'd1);
      repeat (8) @(negedge clk);
      rchk(2'd0, 2'b10, 32'd0);
      rchk(2'd0, 2'b11, 32'h7FFF_FFF5);
      @(negedge clk); clr_overrun = 1'b1;
      @(negedge clk); clr_overrun = 1'b0;
      chk("ovr cleared again", {31'd0, overrun}, 32'd0);

      // Reset in the second CALC cycle aborts with no commit and no done.
      wr(2'd0, 32'd77);
      @(negedge clk); update = 1'b1;
      @(negedge clk); update = 1'b0;
      @(negedge clk); N_reset = 1'b0;
      #1;
      chk("abort busy", {31'd0, busy}, 32'd0);
      @(negedge clk); N_reset = 1'b1;
      dp = 0;
      for (int k = 0; k < 8; k++) begin
        @(negedge clk);
        if (done) dp++;
      end
      chk("abort done pulses", 32'(dp), 32'd0);
      for (int a = 0; a < 3; a++)
        for (int s = 0; s < 4; s++) rchk(2'(a), 2'(s), 32'd0);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/motion_setpoint_table.md
Name: motion_setpoint_table

Overview:
- Parametrised per-axis setpoint/velocity table for the closed-loop motion datapath; generalises the fixed 3-axis update table to N axes and configurable width.
- Host writes double-buffered (shadow) targets; an `update` strobe snapshots all shadow targets.
- A serial one-axis-per-cycle engine computes saturated velocity and acceleration, then commits all axes atomically.
- Sits between the command register file and the trajectory/PWM stages.

Parameters:
- N_AXES, 3, number of axes (≥1).
- W, 32, signed data width of position, velocity and acceleration.
- AW, $clog2(N_AXES) (minimum 1), axis index width (derived, localparam).
- VEL_LIMIT, 2**(W-2), magnitude bound used only when the clamp feature is compiled in.

Ports:
- clk  in  1  clock.
- N_reset  in  1  asynchronous active-low reset.
- we  in  1  shadow target write enable.
- wa  in  AW  shadow write axis.
- wd  in  W  shadow write data (signed).
- update  in  1  one-cycle strobe: start a table update.
- clr_overrun  in  1  clears the overrun flag.
- ra  in  AW  read axis.
- rsel  in  2  read field: 00 current position, 01 shadow target, 10 velocity, 11 acceleration.
- rd  out  W  combinational read data.
- busy  out  1  update engine active.
- done  out  1  one-cycle pulse after commit.
- overrun  out  1  sticky flag: update arrived while busy.

Behaviour:
- Reset is asynchronous on N_reset low: all shadow/active targets, current positions, velocities, accelerations and staging registers go to 0; FSM goes to IDLE; busy, done and overrun go to 0. Reset mid-update aborts it with no partial commit.
- FSM states: IDLE, CALC, COMMIT.
- IDLE→CALC: on the edge where update=1.
  - active_tgt[i] <= shadow[i] for all axes.
  - idx <= 0.
- CALC, each edge: for axis idx:
  - v = sat_W(active_tgt[idx] − cur[idx]), difference formed in W+1 bits.
  - a = sat_W(v − vel[idx]), difference formed in W+1 bits.
  - Store v and a in the staging registers; idx increments.
  - At idx = N_AXES−1, go to COMMIT.
- COMMIT edge, all axes at once:
  - cur <= active_tgt.
  - vel <= stg_vel.
  - acc <= stg_acc.
  - FSM → IDLE; done=1 for exactly the following cycle.
- busy = (state ≠ IDLE). Update latency: strobe edge T → commit edge T+N_AXES+1; done is high in the cycle after that edge.
- Saturation: values above 2^(W−1)−1 clamp to 2^(W−1)−1; values below −2^(W−1) clamp to −2^(W−1). No wrap-around ever.
- Writes:
  - Writes to the shadow targets are accepted in any state.
  - A write in the same cycle as an accepted update lands in the shadow only; the snapshot takes the pre-write value.
  - Writes with wa ≥ N_AXES are ignored.
- Update while busy is ignored and sets overrun=1 on that edge. clr_overrun clears it; if clr_overrun and a new overrun occur in the same cycle, set wins.
- Reads:
  - Reads return committed values only; during CALC they show the previous update's data.
  - ra ≥ N_AXES reads 0.
  - rsel=01 returns the shadow target.

Optional Feature:
- Macro: MOTION_VEL_CLAMP_EN.
- Defined: after saturation, v is further clamped to [−VEL_LIMIT, +VEL_LIMIT].
  - Acceleration uses the clamped v.
  - The committed cur[i] becomes cur[i] + clamped v (W+1-bit sum, saturated), so the position trails the target when the limit is hit.
- Undefined: no clamp; cur[i] = active_tgt[i] at commit; VEL_LIMIT is unused.

Decomposition:
- Package motion_pkg:
  - rsel encoding enum (RSEL_POS, RSEL_TGT, RSEL_VEL, RSEL_ACC).
  - FSM state enum.
  - Saturating-subtract function sat_sub(a, b, W).
- One natural sub-module: motion_axis_calc (combinational per-axis velocity/acceleration/clamp), instantiated once and time-shared by the FSM.

Test Plan:
- Reset, then read all rsel for axes 0..2 → 0; busy=0, done=0, overrun=0.
- Write tgt 100, −50, 7 to axes 0..2, pulse update:
  - busy is high for 4 cycles; done pulses once.
  - Velocities read 100, −50, 7; accelerations 100, −50, 7; positions read 100, −50, 7.
- Second update with tgt0=150 → vel0=50, acc0=−50; unchanged axes show vel=0 and acc equal to minus their previous velocity.
- tgt0=0x7FFFFFFF, cur0=0x80000000 → vel0 saturates to 0x7FFFFFFF, with no wrap.
- Update pulsed during CALC → ignored, overrun=1, result matches the single update. clr_overrun → overrun returns to 0.
- Assert N_reset in the 2nd CALC cycle → all values 0, no done pulse.
- With MOTION_VEL_CLAMP_EN and VEL_LIMIT=10, tgt0=25:
  - First update: vel=10, pos=10.
  - Second update: vel=10, pos=20.
  - Third update: vel=5, pos=25.
